// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// the counter-width helper.
package md_defs;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_MULT  = 4'd0;
    localparam logic [OP_W-1:0] OP_MULTU = 4'd1;
    localparam logic [OP_W-1:0] OP_DIV   = 4'd2;
    localparam logic [OP_W-1:0] OP_DIVU  = 4'd3;
    localparam logic [OP_W-1:0] OP_MADD  = 4'd4;
    localparam logic [OP_W-1:0] OP_MADDU = 4'd5;
    localparam logic [OP_W-1:0] OP_MSUB  = 4'd6;
    localparam logic [OP_W-1:0] OP_MSUBU = 4'd7;
    localparam logic [OP_W-1:0] OP_MTHI  = 4'd8;
    localparam logic [OP_W-1:0] OP_MTLO  = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    // Bits needed to hold the larger of the two busy periods.
    function automatic int unsigned cnt_width(int unsigned mult_cycles,
                                              int unsigned div_cycles);
        int unsigned max_c;
        max_c = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return $clog2(max_c + 1);
    endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational datapath: turns latched op/operands/{hi,lo} snapshot into
// the next {hi,lo}. A divide by zero returns the snapshot unchanged.
module md_compute
    import md_defs::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi_s,
    input  logic [WIDTH-1:0] lo_s,
    output logic [WIDTH-1:0] hi_c,
    output logic [WIDTH-1:0] lo_c
);

    localparam int unsigned W2 = 2 * WIDTH;

    logic [W2-1:0] acc;
    logic [W2-1:0] prod_s;
    logic [W2-1:0] prod_u;
    logic [W2-1:0] res;

    logic              b_zero;
    logic              div_ovf;
    logic [WIDTH-1:0]  div_b;
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic signed [WIDTH-1:0] qs;
    logic signed [WIDTH-1:0] rs;
    logic [WIDTH-1:0]  qu;
    logic [WIDTH-1:0]  ru;

    assign acc = {hi_s, lo_s};

    // Sign-extending to 2*WIDTH makes an unsigned multiply yield the signed product.
    assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign prod_u = {WIDTH'(0), a} * {WIDTH'(0), b};

    assign b_zero  = (b == WIDTH'(0));
    assign div_ovf = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}});
    // Divisor forced to 1 on zero/overflow so the divider never sees an undefined case.
    assign div_b   = (b_zero || div_ovf) ? WIDTH'(1) : b;

    assign sa = $signed(a);
    assign sb = $signed(div_b);
    assign qs = sa / sb;
    assign rs = sa % sb;
    assign qu = a / div_b;
    assign ru = a % div_b;

    always_comb begin
        res = acc;
        case (op)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_MADD:  res = acc + prod_s;
            OP_MADDU: res = acc + prod_u;
            OP_MSUB:  res = acc - prod_s;
            OP_MSUBU: res = acc - prod_u;
            OP_DIV: begin
                if (div_ovf) begin
                    res = {WIDTH'(0), a};
                end else if (!b_zero) begin
                    res = {WIDTH'(rs), WIDTH'(qs)};
                end
            end
            OP_DIVU: begin
                if (!b_zero) begin
                    res = {ru, qu};
                end
            end
            default: res = acc;
        endcase
    end

    assign hi_c = res[W2-1:WIDTH];
    assign lo_c = res[WIDTH-1:0];

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. Latency is imposed
// by a down-counter; the arithmetic itself lives in md_compute.
module md_unit
    import md_defs::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = cnt_width(MULT_CYCLES, DIV_CYCLES);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] snap_hi_q, snap_hi_d;
    logic [WIDTH-1:0] snap_lo_q, snap_lo_d;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic             busy_d;
    logic [WIDTH-1:0] res_hi_c, res_lo_c;

    md_compute #(
        .WIDTH (WIDTH)
    ) u_compute (
        .op   (op_q),
        .a    (a_q),
        .b    (b_q),
        .hi_s (snap_hi_q),
        .lo_s (snap_lo_q),
        .hi_c (res_hi_c),
        .lo_c (res_lo_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            snap_hi_q <= '0;
            snap_lo_q <= '0;
            hi        <= '0;
            lo        <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            snap_hi_q <= snap_hi_d;
            snap_lo_q <= snap_lo_d;
            hi        <= hi_d;
            lo        <= lo_d;
            busy      <= busy_d;
        end
    end

    // Next-state: issue in IDLE, count down in RUN, commit on the last count.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        snap_hi_d = snap_hi_q;
        snap_lo_d = snap_lo_q;
        hi_d      = hi;
        lo_d      = lo;
        busy_d    = busy;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start && !flush) begin
                    case (op)
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
                        OP_MSUB, OP_MSUBU: begin
                            op_d      = op;
                            a_d       = a;
                            b_d       = b;
                            snap_hi_d = hi;
                            snap_lo_d = lo;
                            cnt_d     = CW'(MULT_CYCLES);
                            state_d   = RUN;
                            busy_d    = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_d      = op;
                            a_d       = a;
                            b_d       = b;
                            snap_hi_d = hi;
                            snap_lo_d = lo;
                            cnt_d     = CW'(DIV_CYCLES);
                            state_d   = RUN;
                            busy_d    = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                busy_d = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q == CW'(1)) begin
                    hi_d    = res_hi_c;
                    lo_d    = res_lo_c;
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule
